// File: rtl/decode_queue.sv
// RV32I (+ optional M) instruction decoder feeding a small FIFO of decoded bundles.
// Decode is combinational on the incoming word; the head entry drives all outputs.
module decode_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic [XLEN-1:0]        pc_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             alu_ctrl,
  output logic [1:0]             alu_src_a,
  output logic                   alu_src_b,
  output logic                   reg_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   branch,
  output logic                   jump,
  output logic [2:0]             funct3_o,
  output logic                   md_op,
  output logic                   illegal,
  output logic [XLEN-1:0]        imm,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [XLEN-1:0]        pc_o,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic [1:0]      alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic            md_op;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        legal;
  bundle_t     dec;
  bundle_t     head;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push, pop;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    dec           = '0;
    dec.funct3    = funct3;
    dec.rd        = instr[11:7];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.pc        = pc_i;
    dec.alu_src_b = 1'b1;
    legal         = 1'b1;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b0;
        if (funct7 == 7'b0000000)
          dec.alu_ctrl = {1'b0, funct3};
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_ctrl = {1'b1, funct3};
        else if (funct7 == 7'b0000001 && ENABLE_M)
          dec.md_op = 1'b1;
        else
          legal = 1'b0;
      end
      OP_IMM: begin
        // imm[10] only selects SRAI; ADDI never turns into SUB
        dec.reg_write = 1'b1;
        dec.imm       = sext(imm_i);
        dec.alu_ctrl  = {1'b0, funct3};
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          legal           = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          dec.alu_ctrl[3] = funct7[5];
        end
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = sext(imm_i);
        legal          = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.imm       = sext(imm_s);
        legal         = (funct3 < 3'b011);
      end
      OP_BR: begin
        dec.branch    = 1'b1;
        dec.alu_ctrl  = 4'b1000;
        dec.alu_src_b = 1'b0;
        dec.imm       = sext(imm_b);
        legal         = (funct3[2:1] != 2'b01);
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = sext(imm_j);
        dec.alu_src_a = 2'b01;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = sext(imm_i);
        legal         = (funct3 == 3'b000);
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.imm       = sext(imm_u);
        dec.alu_src_a = 2'b10;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm       = sext(imm_u);
        dec.alu_src_a = 2'b01;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still travel down the pipe so execute can trap on their pc.
    if (!legal) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.md_op     = 1'b0;
    end
  end

  assign in_ready  = (count_reg < CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  bundle_t [DEPTH-1:0] entry_flat;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      bundle_t entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == AW'(gi)))
          entry_reg <= dec;
      end
      assign entry_flat[gi] = entry_reg;
    end
  endgenerate

  assign head       = entry_flat[rd_ptr_reg];
  assign alu_ctrl   = head.alu_ctrl;
  assign alu_src_a  = head.alu_src_a;
  assign alu_src_b  = head.alu_src_b;
  assign reg_write  = head.reg_write;
  assign mem_read   = head.mem_read;
  assign mem_write  = head.mem_write;
  assign mem_to_reg = head.mem_to_reg;
  assign branch     = head.branch;
  assign jump       = head.jump;
  assign funct3_o   = head.funct3;
  assign md_op      = head.md_op;
  assign illegal    = head.illegal;
  assign imm        = head.imm;
  assign rd         = head.rd;
  assign rs1        = head.rs1;
  assign rs2        = head.rs2;
  assign pc_o       = head.pc;
  assign count      = count_reg;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: two instances (M off / M on) share one stimulus stream,
// expected bundles come from an arithmetic reference decoder and are checked as heads pop.
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_ADDI = 32'hFFF50513;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_MUL  = 32'h02B50533;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc_i = '0;
  always #5 clk = ~clk;

  logic            in_ready_w [2], out_valid_w [2], alu_src_b_w [2], reg_write_w [2];
  logic            mem_read_w [2], mem_write_w [2], mem_to_reg_w [2], branch_w [2];
  logic            jump_w [2], md_op_w [2], illegal_w [2];
  logic [3:0]      alu_ctrl_w [2];
  logic [1:0]      alu_src_a_w [2];
  logic [2:0]      funct3_w [2];
  logic [XLEN-1:0] imm_w [2], pc_o_w [2];
  logic [4:0]      rd_w [2], rs1_w [2], rs2_w [2];
  logic [CW-1:0]   count_w [2];

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .instr(instr), .pc_i(pc_i), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl_w[0]), .alu_src_a(alu_src_a_w[0]), .alu_src_b(alu_src_b_w[0]),
    .reg_write(reg_write_w[0]), .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]),
    .mem_to_reg(mem_to_reg_w[0]), .branch(branch_w[0]), .jump(jump_w[0]),
    .funct3_o(funct3_w[0]), .md_op(md_op_w[0]), .illegal(illegal_w[0]), .imm(imm_w[0]),
    .rd(rd_w[0]), .rs1(rs1_w[0]), .rs2(rs2_w[0]), .pc_o(pc_o_w[0]), .count(count_w[0]));

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_M(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .instr(instr), .pc_i(pc_i), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl_w[1]), .alu_src_a(alu_src_a_w[1]), .alu_src_b(alu_src_b_w[1]),
    .reg_write(reg_write_w[1]), .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]),
    .mem_to_reg(mem_to_reg_w[1]), .branch(branch_w[1]), .jump(jump_w[1]),
    .funct3_o(funct3_w[1]), .md_op(md_op_w[1]), .illegal(illegal_w[1]), .imm(imm_w[1]),
    .rd(rd_w[1]), .rs1(rs1_w[1]), .rs2(rs2_w[1]), .pc_o(pc_o_w[1]), .count(count_w[1]));

  typedef struct {
    logic        illegal, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, md_op, alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_src_a;
    logic [2:0]  funct3;
    logic [31:0] imm, pc;
    logic [4:0]  rd, rs1, rs2;
    bit          chk_ctl, chk_alu, chk_sb;
  } exp_t;

  exp_t        q0 [$], q1 [$];
  int          n_cmp = 0, n_bad = 0;
  bit          pend_push = 0, pend_flush = 0;
  logic [31:0] pend_ins = '0, pend_pc = '0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  // ALU codes by mnemonic for the non-alternate funct3 operations
  function automatic logic [3:0] alu_code(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'b0000;  // ADD
      3'd1: return 4'b0001;  // SLL
      3'd2: return 4'b0010;  // SLT
      3'd3: return 4'b0011;  // SLTU
      3'd4: return 4'b0100;  // XOR
      3'd5: return 4'b0101;  // SRL
      3'd6: return 4'b0110;  // OR
      default: return 4'b0111;  // AND
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit em);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic signed [31:0] s;
    logic ok;
    e = '{default: 0};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; s = ins;
    e.funct3 = f3; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.pc = pc;
    e.alu_src_b = 1'b1;
    ok = 1'b1;
    case (op)
      7'h33: begin
        e.reg_write = 1; e.alu_src_b = 0; e.chk_sb = 1; e.imm = 0;
        if (f7 == 7'h00) begin e.alu_ctrl = alu_code(f3); e.chk_alu = 1; end
        else if (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) begin
          e.alu_ctrl = (f3 == 3'd0) ? 4'b1000 : 4'b1101; e.chk_alu = 1;
        end
        else if (f7 == 7'h01 && em) e.md_op = 1;
        else ok = 0;
      end
      7'h13: begin
        e.reg_write = 1; e.chk_sb = 1; e.chk_alu = 1; e.imm = 32'(s >>> 20);
        e.alu_ctrl = alu_code(f3);
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) begin
          ok = f7 inside {7'h00, 7'h20};
          if (f7 == 7'h20) e.alu_ctrl = 4'b1101;
        end
      end
      7'h03: begin
        e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; e.chk_alu = 1; e.imm = 32'(s >>> 20);
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        e.mem_write = 1; e.chk_alu = 1;
        e.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        e.branch = 1; e.alu_ctrl = 4'b1000; e.chk_alu = 1; e.alu_src_b = 0; e.chk_sb = 1;
        e.imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        ok = !(f3 inside {3'd2, 3'd3});
      end
      7'h6F: begin
        e.jump = 1; e.reg_write = 1; e.alu_src_a = 2'b01;
        e.imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67: begin
        e.jump = 1; e.reg_write = 1; e.imm = 32'(s >>> 20); ok = (f3 == 3'd0);
      end
      7'h37: begin e.reg_write = 1; e.alu_src_a = 2'b10; e.chk_alu = 1; e.imm = ins & 32'hFFFFF000; end
      7'h17: begin e.reg_write = 1; e.alu_src_a = 2'b01; e.chk_alu = 1; e.imm = ins & 32'hFFFFF000; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.illegal = 1; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jump = 0; e.md_op = 0; e.chk_alu = 0; e.chk_sb = 0;
    end else begin
      e.chk_ctl = 1;
    end
    return e;
  endfunction

  function automatic exp_t actual(input int k);
    exp_t a;
    a = '{default: 0};
    a.illegal = illegal_w[k]; a.reg_write = reg_write_w[k]; a.mem_read = mem_read_w[k];
    a.mem_write = mem_write_w[k]; a.mem_to_reg = mem_to_reg_w[k]; a.branch = branch_w[k];
    a.jump = jump_w[k]; a.md_op = md_op_w[k]; a.alu_src_b = alu_src_b_w[k];
    a.alu_ctrl = alu_ctrl_w[k]; a.alu_src_a = alu_src_a_w[k]; a.funct3 = funct3_w[k];
    a.imm = imm_w[k]; a.pc = pc_o_w[k]; a.rd = rd_w[k]; a.rs1 = rs1_w[k]; a.rs2 = rs2_w[k];
    return a;
  endfunction

  task automatic compare(input int k, input exp_t a, input exp_t e);
    string t;
    t = $sformatf("dut%0d pc=%08h", k, e.pc);
    chk({t, " illegal"}, a.illegal, e.illegal);
    chk({t, " reg_write"}, a.reg_write, e.reg_write);
    chk({t, " mem_read"}, a.mem_read, e.mem_read);
    chk({t, " mem_write"}, a.mem_write, e.mem_write);
    chk({t, " branch"}, a.branch, e.branch);
    chk({t, " jump"}, a.jump, e.jump);
    chk({t, " md_op"}, a.md_op, e.md_op);
    chk({t, " funct3_o"}, a.funct3, e.funct3);
    chk({t, " regs"}, {a.rd, a.rs1, a.rs2}, {e.rd, e.rs1, e.rs2});
    chk({t, " pc_o"}, a.pc, e.pc);
    if (e.chk_ctl) begin
      chk({t, " mem_to_reg"}, a.mem_to_reg, e.mem_to_reg);
      chk({t, " alu_src_a"}, a.alu_src_a, e.alu_src_a);
      chk({t, " imm"}, a.imm, e.imm);
    end
    if (e.chk_alu) chk({t, " alu_ctrl"}, a.alu_ctrl, e.alu_ctrl);
    if (e.chk_sb)  chk({t, " alu_src_b"}, a.alu_src_b, e.alu_src_b);
  endtask

  // Monitor: occupancy/handshake each cycle, head contents whenever execute takes one.
  always @(negedge clk) begin
    int   sz;
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        sz = (k == 0) ? q0.size() : q1.size();
        chk($sformatf("dut%0d count", k), count_w[k], sz);
        chk($sformatf("dut%0d in_ready", k), in_ready_w[k], sz < DEPTH);
        chk($sformatf("dut%0d out_valid", k), out_valid_w[k], sz != 0);
        if (!flush && out_ready && sz != 0) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          compare(k, actual(k), e);
          if (k == 0) $display("pop pc=%08h illegal=%0d imm=%08h", e.pc, e.illegal, e.imm);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                      input bit ordy, input bit fl);
    @(posedge clk);
    if (pend_flush) begin
      q0.delete(); q1.delete();
    end else if (pend_push) begin
      q0.push_back(model(pend_ins, pend_pc, 1'b0));
      q1.push_back(model(pend_ins, pend_pc, 1'b1));
    end
    #1;
    in_valid = v; instr = ins; pc_i = p; out_ready = ordy; flush = fl;
    pend_flush = fl;
    pend_push  = v && !fl && (q0.size() < DEPTH);
    pend_ins   = ins;
    pend_pc    = p;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] r;
    int          pick;
    r = $urandom;
    pick = $urandom_range(0, 10);
    if (pick < 9) r[6:0] = ops[pick];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  task automatic drain();
    repeat (DEPTH + 1) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset count", count_w[0], 0);
    chk("reset in_ready", in_ready_w[0], 1);
    chk("reset out_valid", out_valid_w[0], 0);
    chk("reset imm/pc", {imm_w[0], pc_o_w[0]}, 0);
    @(negedge clk); #1 rst = 1'b0;

    // sub then addi, third word held off while full
    step(1, I_SUB, 32'h100, 0, 0);
    step(1, I_ADDI, 32'h104, 0, 0);
    step(1, I_BEQ, 32'h108, 0, 0);
    @(negedge clk);
    chk("full count", count_w[0], 2);
    chk("full in_ready", in_ready_w[0], 0);
    chk("sub alu_ctrl", alu_ctrl_w[0], 4'b1000);
    chk("sub reg_write", reg_write_w[0], 1);
    chk("sub alu_src_b", alu_src_b_w[0], 0);
    step(1, I_BEQ, 32'h108, 1, 0);
    @(negedge clk);
    chk("full+pop in_ready", in_ready_w[0], 0);
    step(0, '0, '0, 0, 0);
    @(negedge clk);
    chk("addi alu_ctrl", alu_ctrl_w[0], 4'b0000);
    chk("addi imm", imm_w[0], 32'hFFFFFFFF);
    chk("addi alu_src_b", alu_src_b_w[0], 1);
    for (int i = 0; i < 6; i++) step(1, rand_instr(), 32'h200 + 4 * i, 1, 0);
    drain();

    // beq and lui heads
    step(1, I_BEQ, 32'h300, 0, 0);
    step(1, I_LUI, 32'h304, 0, 0);
    step(0, '0, '0, 0, 0);
    @(negedge clk);
    chk("beq branch", branch_w[0], 1);
    chk("beq imm", imm_w[0], 32'hFFFFFFFC);
    chk("beq alu_ctrl", alu_ctrl_w[0], 4'b1000);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 0, 0);
    @(negedge clk);
    chk("lui imm", imm_w[0], 32'h12345000);
    chk("lui alu_src_a", alu_src_a_w[0], 2'b10);
    drain();

    // mul with and without the M extension
    step(1, I_MUL, 32'h400, 0, 0);
    step(0, '0, '0, 0, 0);
    @(negedge clk);
    chk("mul M=0 illegal", illegal_w[0], 1);
    chk("mul M=0 reg_write", reg_write_w[0], 0);
    chk("mul M=1 md_op", md_op_w[1], 1);
    chk("mul M=1 funct3_o", funct3_w[1], 3'b000);
    chk("mul M=1 illegal", illegal_w[1], 0);
    drain();

    // flush while full with a push attempt, then flush with room for the push
    step(1, I_SUB, 32'h500, 0, 0);
    step(1, I_ADDI, 32'h504, 0, 0);
    step(1, I_LUI, 32'h508, 1, 1);
    step(0, '0, '0, 0, 0);
    @(negedge clk);
    chk("flush count", count_w[0], 0);
    chk("flush out_valid", out_valid_w[0], 0);
    step(1, I_BEQ, 32'h520, 0, 0);
    step(1, I_LUI, 32'h524, 0, 1);
    step(0, '0, '0, 1, 0);
    @(negedge clk);
    chk("flush2 count", count_w[0], 0);
    drain();

    // asynchronous reset with two entries held
    step(1, I_SUB, 32'h600, 0, 0);
    step(1, I_ADDI, 32'h604, 0, 0);
    step(0, '0, '0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst count", count_w[0], 0);
    chk("async rst out_valid", out_valid_w[0], 0);
    chk("async rst in_ready", in_ready_w[0], 1);
    chk("async rst outputs", {alu_ctrl_w[0], reg_write_w[0], rd_w[0], imm_w[0], pc_o_w[0]}, 0);
    q0.delete(); q1.delete();
    pend_push = 0; pend_flush = 0;
    @(negedge clk); #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom} & 32'hFFFFFFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    drain();
    @(negedge clk); #1;
    chk("final queue empty", count_w[0], q0.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised successor to the team's combinational RV ALU-control decoder.
- Decodes full RV32I: R/I-arith, load, store, branch, JAL, JALR, LUI, AUIPC. Optional M-extension via parameter.
- Generates sign-extended immediates and an illegal-instruction flag.
- Decoded bundles are buffered in a small FIFO with valid/ready handshakes and flush. Sits between fetch and execute.

Parameters:
XLEN, 32, datapath/immediate/PC width; legal values 32 or 64 (RV64 W-ops not decoded, reported illegal)
DEPTH, 2, decoded-bundle FIFO entries; power of two, >= 2
ENABLE_M, 0, 1 = decode funct7=0000001 R-type as mul/div; 0 = illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all buffered entries and any same-cycle input
in_valid  in  1  fetch presents instruction
in_ready  out  1  queue accepts; = (count < DEPTH)
instr  in  32  instruction word
pc_i  in  XLEN  instruction address
out_valid  out  1  head entry valid; = (count != 0)
out_ready  in  1  execute consumes head
alu_ctrl  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
alu_src_a  out  2  00 rs1, 01 pc, 10 zero
alu_src_b  out  1  1 = imm, 0 = rs2
reg_write, mem_read, mem_write, mem_to_reg, branch, jump  out  1 each  control strobes
funct3_o  out  3  raw funct3 (load/store size, branch condition, md op)
md_op  out  1  mul/div instruction (only when ENABLE_M)
illegal  out  1  undecodable instruction
imm  out  XLEN  sign-extended immediate (I/S/B/U/J per format; 0 for R-type)
rd, rs1, rs2  out  5 each  register indices
pc_o  out  XLEN  pc of head entry
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async assert): count=0, pointers=0, all storage cleared. All outputs 0 except in_ready=1.
- Push when in_valid && in_ready && !flush. Decode is combinational on instr and written into the tail entry.
- Latency: an accepted instruction appears at out_valid/head one cycle after acceptance (no combinational bypass).
- Pop when out_valid && out_ready. Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, in_ready=0 even if a pop occurs that cycle; no pop-to-push bypass.
- Pointers wrap modulo DEPTH.
- flush: next edge sets count=0 and pointers=0. Same-cycle push and pop are ignored. Flush beats everything except rst.
- Outputs reflect the head entry whenever out_valid=1. When out_valid=0, outputs hold the last head contents and are don't-care; the bench must not check them.
- Decode table:
  - R 0110011: reg_write; alu_src_b=0; ALU op per alu_ctrl encoding. funct7=0100000 is legal only with funct3 000/101. funct7=0000001 gives md_op=1 when ENABLE_M, else illegal. Any other funct7 is illegal.
  - I-arith 0010011: reg_write; alu_src_b=1. SLLI requires imm[11:5]=0000000. SRLI/SRAI select via imm[11:5] = 0000000/0100000; any other value is illegal. For all other funct3, imm[10] is ignored (ADDI is never SUB).
  - Load 0000011: ADD, mem_read, mem_to_reg, reg_write, I-imm. funct3 011/110/111 are illegal.
  - Store 0100011: ADD, mem_write, S-imm. funct3 > 010 is illegal.
  - Branch 1100011: branch=1, SUB, alu_src_b=0, B-imm. funct3 010/011 are illegal.
  - JAL 1101111: jump, reg_write, J-imm, alu_src_a=01.
  - JALR 1100111: jump, reg_write, I-imm, alu_src_a=00. funct3 != 000 is illegal.
  - LUI 0110111: reg_write, U-imm, alu_src_a=10, ADD.
  - AUIPC 0010111: reg_write, U-imm, alu_src_a=01, ADD.
  - Any other opcode, or instr[1:0] != 11: illegal.
- Illegal entries are still queued (pc kept for trap) with illegal=1. reg_write, mem_read, mem_write, branch, jump and md_op are forced 0 for them.
- Immediates are sign-extended from instr[31] to XLEN. U-imm = {instr[31:12], 12'b0}, sign-extended when XLEN=64.

Test Plan:
- Reset with rst high mid-stream holding 2 entries -> count=0, out_valid=0, in_ready=1 immediately; outputs 0.
- Push 0x40B50533 (sub a0,a0,a1), then addi a0,a0,-1 (0xFFF50513) -> head1: alu_ctrl=1000, reg_write=1, alu_src_b=0. head2: alu_ctrl=0000, imm=0xFFFFFFFF, alu_src_b=1.
- Fill DEPTH=2 with out_ready=0 -> in_ready=0 at count=2. Third instruction held off. Then out_ready=1 with in_valid=1 -> pops each cycle; order preserved across pointer wrap.
- Push 0x02B50533 (mul) with ENABLE_M=0 -> illegal=1, reg_write=0. With ENABLE_M=1 -> md_op=1, funct3_o=000, illegal=0.
- beq x1,x2,-4 (0xFE208EE3) -> branch=1, imm=0xFFFFFFFC, alu_ctrl=1000. lui x5,0x12345 -> imm=0x12345000, alu_src_a=10.
- flush asserted with count=2 plus a same-cycle push -> next cycle count=0, out_valid=0, pushed instruction never appears.
